// File: rtl/sal_rd_resp_merger.sv
// sal_rd_resp_merger
//
// Merges the read-beat streams of BK_CNT bank controllers onto a single AXI R
// channel. Banks are served round-robin at burst granularity. Once a
// multi-beat burst starts, the merger stays locked on that bank until its last
// beat, so bursts from different banks are never interleaved. The R outputs
// are registered and form a one-entry skid slot, which gives exactly one cycle
// of latency and full throughput while rready is held high.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bk_rvalid  in   [BK_CNT]             per-bank beat valid
//   bk_rid     in   [BK_CNT*ID_WIDTH]    per-bank beat ID, bank i in slice i
//   bk_rdata   in   [BK_CNT*DATA_WIDTH]  per-bank beat data, bank i in slice i
//   bk_rlast   in   [BK_CNT]             per-bank last beat of burst
//   bk_rready  out  [BK_CNT]             per-bank beat accept (combinational)
//   rvalid     out  AXI R valid (registered)
//   rid        out  AXI R ID (registered)
//   rdata      out  AXI R data (registered)
//   rresp      out  AXI R response, always OKAY
//   rlast      out  AXI R last (registered)
//   rready     in   AXI R ready from the interconnect
//   err_id     out  sticky: a locked burst changed its ID part-way through
//
// FSM states
//   state | meaning
//   IDLE  | between bursts; round-robin search starts at rr_ptr
//   LOCK  | inside a multi-beat burst; only lock_bk is served

module sal_rd_resp_merger #(
  parameter int BK_CNT     = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BK_CNT-1:0]            bk_rvalid,
  input  logic [BK_CNT*ID_WIDTH-1:0]   bk_rid,
  input  logic [BK_CNT*DATA_WIDTH-1:0] bk_rdata,
  input  logic [BK_CNT-1:0]            bk_rlast,
  output logic [BK_CNT-1:0]            bk_rready,
  output logic                         rvalid,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  input  logic                         rready,
  output logic                         err_id
);

  localparam int PTR_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        lock_bk;
  logic [ID_WIDTH-1:0]     lock_id;

  logic [PTR_W-1:0]        grant;
  logic                    grant_vld;
  logic                    slot_free;
  logic                    xfer;

  logic [ID_WIDTH-1:0]     grant_id;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic                    grant_last;

  // Round-robin pick: first requester at or above ptr, wrapping to 0.
  // Scanning from the far end down lets the nearest requester win last.
  // Returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [BK_CNT-1:0] req,
                                             input logic [PTR_W-1:0]  ptr);
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int k = BK_CNT - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // The output register can take a new beat when empty or draining this edge.
  assign slot_free = ~rvalid | rready;

  assign grant_id   = bk_rid[grant*ID_WIDTH +: ID_WIDTH];
  assign grant_data = bk_rdata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign grant_last = bk_rlast[grant];

  assign rresp = 2'b00;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: grant selection, bank accept and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    grant     = '0;
    grant_vld = 1'b0;
    xfer      = 1'b0;
    bk_rready = '0;

    case (state)
      IDLE: begin
        {grant_vld, grant} = rr_pick(bk_rvalid, rr_ptr);
      end
      LOCK: begin
        grant     = lock_bk;
        grant_vld = bk_rvalid[lock_bk];
      end
      default: begin
        grant     = '0;
        grant_vld = 1'b0;
      end
    endcase

    // rst_n gating keeps banks from seeing an accept while the merger is held
    // in reset, when the empty output slot would otherwise look free.
    xfer = grant_vld & slot_free & rst_n;

    if (xfer) begin
      bk_rready[grant] = 1'b1;
    end

    if (xfer) begin
      case (state)
        IDLE:    if (!grant_last) state_nxt = LOCK;
        LOCK:    if (grant_last)  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration bookkeeping and ID consistency check
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      lock_bk <= '0;
      lock_id <= '0;
      err_id  <= 1'b0;
    end else if (xfer) begin
      if (state == IDLE) begin
        if (grant_last) begin
          rr_ptr <= grant + PTR_W'(1);
        end else begin
          lock_bk <= grant;
          lock_id <= grant_id;
        end
      end else begin
        // The beat is still forwarded; the mismatch is only flagged.
        if (grant_id != lock_id) begin
          err_id <= 1'b1;
        end
        if (grant_last) begin
          rr_ptr <= lock_bk + PTR_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // R channel output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rlast  <= 1'b0;
    end else if (xfer) begin
      rvalid <= 1'b1;
      rid    <= grant_id;
      rdata  <= grant_data;
      rlast  <= grant_last;
    end else if (rready) begin
      // Payload is left as-is once consumed; only valid drops.
      rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/sal_rd_resp_merger.md
SAL_RD_RESP_MERGER -- requirements
Module: SAL_RD_RESP_MERGER

Interface
REQ-001 SHALL have parameter BK_CNT, default 4, number of bank controllers (power of 2, 2..8).
REQ-002 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, read data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port bk_rvalid  input  BK_CNT  per-bank read beat valid.
REQ-007 SHALL have port bk_rid  input  BK_CNT*ID_WIDTH  per-bank beat ID; bank i occupies slice i.
REQ-008 SHALL have port bk_rdata  input  BK_CNT*DATA_WIDTH  per-bank beat data.
REQ-009 SHALL have port bk_rlast  input  BK_CNT  per-bank last beat of burst.
REQ-010 SHALL have port bk_rready  output  BK_CNT  per-bank beat accept.
REQ-011 SHALL have port rvalid  output  1  AXI R valid, registered.
REQ-012 SHALL have port rid  output  ID_WIDTH  AXI R ID, registered.
REQ-013 SHALL have port rdata  output  DATA_WIDTH  AXI R data, registered.
REQ-014 SHALL have port rresp  output  2  AXI R response, constant 2'b00 (OKAY).
REQ-015 SHALL have port rlast  output  1  AXI R last, registered.
REQ-016 SHALL have port rready  input  1  AXI R ready from interconnect.
REQ-017 SHALL have port err_id  output  1  sticky flag: ID changed inside a locked burst.

Function
REQ-018 SHALL define slot_free = ~rvalid | rready; a bank beat transfers when bk_rvalid[i] & bk_rready[i].
REQ-019 SHALL assert at most one bk_rready bit per cycle, only for the granted bank, and only when slot_free=1.
REQ-020 SHALL implement FSM states IDLE and LOCK, plus rr_ptr (log2 BK_CNT bits) and lock_bk registers.
REQ-021 In IDLE SHALL grant the first bank with bk_rvalid=1 searching upward from rr_ptr, wrapping BK_CNT-1 -> 0.
REQ-022 In IDLE, on a granted transfer with bk_rlast=1, SHALL stay IDLE and set rr_ptr = grant+1 mod BK_CNT.
REQ-023 In IDLE, on a granted transfer with bk_rlast=0, SHALL go to LOCK, load lock_bk = grant and latch the beat ID.
REQ-024 In LOCK SHALL grant only lock_bk, ignoring all other bk_rvalid bits.
REQ-025 In LOCK, on transfer with bk_rlast=1, SHALL go to IDLE and set rr_ptr = lock_bk+1 mod BK_CNT.
REQ-026 In LOCK, a transferred beat whose bk_rid differs from the latched ID SHALL set err_id, which stays set until reset; data SHALL still be forwarded.
REQ-027 On any transfer SHALL load rvalid=1 and rid/rdata/rlast from the granted bank on the next edge: latency exactly 1 cycle.
REQ-028 SHALL clear rvalid on the edge where rvalid & rready and no new transfer occurs.
REQ-029 SHALL hold rid/rdata/rlast stable while rvalid=1 and rready=0.
REQ-030 SHALL sustain one beat per cycle while rready=1 and the granted bank is valid (back-to-back, no bubble).
REQ-031 SHALL not change rr_ptr in a cycle without a last-beat transfer.
REQ-032 bk_rready SHALL be combinational from state, bk_rvalid, rvalid and rready; there is no other combinational input-to-output path.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE, rr_ptr=0, lock_bk=0, rvalid=0, rlast=0, rid=0, rdata=0, err_id=0, independent of clk.
REQ-034 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from bank 0 in IDLE.
REQ-035 bk_rready SHALL be 0 whenever rst_n=0.

Verification
REQ-036 Single beat: bank 2 rvalid, rid=5, rdata=0xA5, rlast=1, rready=1 -> bk_rready=0100 same cycle; next cycle rvalid=1, rid=5, rdata=0xA5, rlast=1; rr_ptr=3.
REQ-037 Burst lock: bank 0 sends 4-beat burst (rlast on beat 4) while bank 1 continuously valid -> 4 consecutive bank-0 beats on R, then bank 1 granted; no bank-1 beat interleaved.
REQ-038 Round-robin wrap: all 4 banks hold 1-beat bursts, rr_ptr=3 -> grant order 3,0,1,2; a 4-cycle window shows each bank exactly once.
REQ-039 Backpressure: rready=0 for 3 cycles with rvalid=1 -> rdata/rid/rlast unchanged, bk_rready=0; on rready=1, next beat appears the following cycle.
REQ-040 ID error: in LOCK on bank 1 with rid=3, beat 2 arrives with rid=7 -> data forwarded, err_id=1 from next edge and remains 1 after burst end.
REQ-041 Reset mid-burst: rst_n low after beat 2 of a 4-beat bank-3 burst -> outputs zero immediately; after release, bank 0 and bank 3 both valid -> bank 0 granted first.
